// File: rtl/column_scheduler.sv
// Game sequencer for the three falling-letter columns: staggered launch, fall-step
// divider, switch arbitration, score/speed ramp and game-over detection.
module column_scheduler #(
   parameter int unsigned DIV_INIT = 25_000_000,
   parameter int unsigned DIV_MIN  = 5_000_000,
   parameter int unsigned DIV_STEP = 2_500_000,
   parameter int unsigned STAGGER  = 50_000_000,
   parameter int unsigned HOLDOFF  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  match,
   input  logic [14:0] ypos,
   input  logic [2:0]  bottom,
   output logic [2:0]  spawn,
   output logic [2:0]  step,
   output logic [2:0]  clear,
   output logic [7:0]  score,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2, OVER = 2'd3} state_t;

   localparam int unsigned LMAX = 2 * STAGGER;
   localparam int unsigned CMAX = (DIV_INIT > LMAX) ? DIV_INIT : LMAX;
   localparam int CW = $clog2(CMAX + 2);
   localparam int HW = $clog2(HOLDOFF + 2);

   state_t               st;
   logic [CW-1:0]        div;
   logic [CW-1:0]        per;
   logic [CW-1:0]        scnt;
   logic [CW-1:0]        lcnt;
   logic [2:0]           active;
   logic [2:0][HW-1:0]   hold;

   logic [2:0]           elig;
   logic [2:0]           win;
   logic [4:0]           best;
   logic                 found;
   logic [2:0]           lspawn;
   logic                 dead;
   logic                 wrap;
   logic                 speed;
   logic [7:0]           score_nxt;
   logic [CW-1:0]        div_nxt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [CW-1:0] speed_up(input logic [CW-1:0] d);
      if (d >= CW'(DIV_MIN + DIV_STEP))
         return d - CW'(DIV_STEP);
      else
         return CW'(DIV_MIN);
   endfunction

   assign state = st;

   // Largest ypos wins; strict compare keeps the lowest index on ties.
   always_comb begin
      elig  = '0;
      win   = '0;
      best  = '0;
      found = 1'b0;
      for (int i = 0; i < 3; i++)
         elig[i] = active[i] && (hold[i] == '0) && match[i] && !bottom[i];
      for (int i = 0; i < 3; i++) begin
         if (elig[i] && (!found || (ypos[i*5 +: 5] > best))) begin
            win    = '0;
            win[i] = 1'b1;
            best   = ypos[i*5 +: 5];
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      lspawn = '0;
      if (st == LAUNCH) begin
         if (lcnt + CW'(1) == CW'(STAGGER))     lspawn[1] = 1'b1;
         if (lcnt + CW'(1) == CW'(2 * STAGGER)) lspawn[2] = 1'b1;
      end
   end

   assign dead      = ((st == LAUNCH) || (st == RUN)) && |(active & bottom);
   assign wrap      = (scnt == per - CW'(1));
   assign score_nxt = sat_inc(score);
   assign speed     = |win && (score != 8'hFF) && (score_nxt[2:0] == 3'd0);
   assign div_nxt   = speed ? speed_up(div) : div;

   always_ff @(posedge clock) begin
      if (reset) begin
         st     <= IDLE;
         score  <= '0;
         div    <= CW'(DIV_INIT);
         per    <= CW'(DIV_INIT);
         scnt   <= '0;
         lcnt   <= '0;
         active <= '0;
         hold   <= '0;
         spawn  <= '0;
         step   <= '0;
         clear  <= '0;
      end else begin
         spawn <= '0;
         step  <= '0;
         clear <= '0;
         for (int i = 0; i < 3; i++)
            if (hold[i] != '0) hold[i] <= hold[i] - HW'(1);

         case (st)
            IDLE, OVER: begin
               if (start) begin
                  st     <= LAUNCH;
                  score  <= '0;
                  div    <= CW'(DIV_INIT);
                  per    <= CW'(DIV_INIT);
                  scnt   <= '0;
                  lcnt   <= '0;
                  active <= 3'b001;
                  hold   <= '0;
                  spawn  <= 3'b001;
               end
            end
            default: begin
               clear  <= win;
               spawn  <= clear | lspawn;
               active <= active | lspawn;
               div    <= div_nxt;
               if (|win) score <= score_nxt;
               for (int i = 0; i < 3; i++)
                  if (win[i]) hold[i] <= HW'(HOLDOFF);

               // A div change only lands at a period boundary.
               if (wrap) begin
                  scnt <= '0;
                  per  <= div_nxt;
                  step <= active;
               end else begin
                  scnt <= scnt + CW'(1);
               end

               if (st == LAUNCH) begin
                  lcnt <= lcnt + CW'(1);
                  if (active[2]) st <= RUN;
               end

               // Game over overrides everything except clears of other columns.
               if (dead) begin
                  st    <= OVER;
                  spawn <= '0;
                  step  <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_column_scheduler.sv
// Directed bench for column_scheduler with small divider/stagger values.
module tb_column_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  match;
   logic [14:0] ypos;
   logic [2:0]  bottom;
   logic [2:0]  spawn;
   logic [2:0]  step;
   logic [2:0]  clear;
   logic [7:0]  score;
   logic [1:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   column_scheduler #(
      .DIV_INIT(10), .DIV_MIN(4), .DIV_STEP(2), .STAGGER(5), .HOLDOFF(2)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .match(match), .ypos(ypos),
      .bottom(bottom), .spawn(spawn), .step(step), .clear(clear), .score(score),
      .state(state)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Cycles between two consecutive step pulses; -1 if either wait times out.
   task automatic measure_period(output int p);
      int t;
      p = -1;
      t = 0;
      while (step == 3'b000 && t < 40) begin nclk(1); t++; end
      if (step != 3'b000) begin
         t = 0;
         nclk(1);
         t = 1;
         while (step == 3'b000 && t < 40) begin nclk(1); t++; end
         if (step != 3'b000) p = t;
      end
   endtask

   task automatic drive_clears(input int n);
      match = 3'b111;
      nclk(n);
      match = 3'b000;
   endtask

   int p;

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      match  = 3'b000;
      ypos   = {5'd9, 5'd9, 5'd3};
      bottom = 3'b000;
      nclk(2);

      // Reset state
      check("rst_state", state, 0);
      check("rst_score", score, 0);
      check("rst_pulses", {spawn, step, clear}, 0);
      reset = 1'b0;
      nclk(1);

      // Launch: staggered spawns, RUN after column 2, steps every 10 cycles
      start = 1'b1;
      nclk(1);
      start = 1'b0;
      for (int c = 0; c <= 30; c++) begin
         check($sformatf("launch_spawn_c%0d", c), spawn,
               (c == 0) ? 1 : (c == 5) ? 2 : (c == 10) ? 4 : 0);
         check($sformatf("launch_step_c%0d", c), step,
               (c == 10) ? 3 : (c == 20 || c == 30) ? 7 : 0);
         check($sformatf("launch_state_c%0d", c), state, (c <= 10) ? 1 : 2);
         if (c < 30) nclk(1);
      end

      // Arbitration: tie between columns 1 and 2 at row 9, column 0 at row 3
      match = 3'b111;
      for (int k = 1; k <= 8; k++) begin
         nclk(1);
         check($sformatf("arb_score_k%0d", k), score, k);
         if (k == 1) check("arb_clear1", clear, 3'b010);
         if (k == 2) begin
            check("arb_clear2", clear, 3'b100);
            check("arb_spawn2", spawn, 3'b010);
         end
         if (k == 3) begin
            check("arb_clear3", clear, 3'b001);
            check("arb_spawn3", spawn, 3'b100);
         end
      end
      match = 3'b000;

      // Speed-up ramp: 8 -> 8, 24 -> 4, 32 -> stays 4
      measure_period(p);
      check("period_at_8", p, 8);
      drive_clears(16);
      check("score_24", score, 24);
      measure_period(p);
      check("period_at_24", p, 4);
      drive_clears(8);
      check("score_32", score, 32);
      measure_period(p);
      check("period_at_32", p, 4);

      // Bottom and match on the same column: game over, no credit
      nclk(3);
      match  = 3'b001;
      bottom = 3'b001;
      nclk(1);
      check("over_clear", clear, 0);
      check("over_score", score, 32);
      check("over_state", state, 3);
      match  = 3'b000;
      bottom = 3'b000;
      for (int c = 0; c < 12; c++) begin
         nclk(1);
         check($sformatf("over_pulses_c%0d", c), {spawn, step, clear}, 0);
      end
      check("over_score_held", score, 32);
      check("over_state_held", state, 3);

      // Restart from OVER
      start = 1'b1;
      nclk(1);
      start = 1'b0;
      check("restart_state", state, 1);
      check("restart_score", score, 0);
      check("restart_spawn", spawn, 3'b001);

      // Reset mid-run with score 17
      nclk(11);
      check("run_state", state, 2);
      match = 3'b111;
      nclk(17);
      check("score_17", score, 17);
      reset = 1'b1;
      nclk(1);
      check("midrst_state", state, 0);
      check("midrst_score", score, 0);
      check("midrst_pulses", {spawn, step, clear}, 0);
      reset = 1'b0;
      match = 3'b000;
      nclk(1);

      // Saturation after 300 clears
      start = 1'b1;
      nclk(1);
      start = 1'b0;
      nclk(11);
      check("sat_run_state", state, 2);
      match = 3'b111;
      for (int k = 1; k <= 300; k++) begin
         nclk(1);
         if (k == 254 || k == 255 || k == 300)
            check($sformatf("sat_score_k%0d", k), score, (k < 255) ? k : 255);
      end
      match = 3'b000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/column_scheduler.md
# column_scheduler

Sequences the three falling-letter columns of the game. It launches the columns with staggered spawns and generates their fall-step ticks from a programmable divider. It also arbitrates the shared switch input, so only one column is credited per cycle when its letter matches. It owns the score, the speed-up ramp and game-over detection, and sits between the button and switch inputs and the `Column` instances, ahead of the display path.

## Interface
- `DIV_INIT`, 25_000_000: clock cycles per fall step at game start.
- `DIV_MIN`, 5_000_000: floor for the fall-step period.
- `DIV_STEP`, 2_500_000: period decrement applied every 8 points.
- `STAGGER`, 50_000_000: cycles between successive column spawns at launch.
- `HOLDOFF`, 2: cycles a column is ineligible for arbitration after its clear.

- `clock`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse, already debounced.
- `match`  in  3  bit i is high when column i's letter equals the switch input.
- `ypos`  in  15  packed {ypos3, ypos2, ypos1}, 5 bits each; row of each column.
- `bottom`  in  3  bit i is high when column i has reached the last row.
- `spawn`  out  3  one-cycle pulse; column i loads a new letter at the top row.
- `step`  out  3  one-cycle pulse; column i advances one row.
- `clear`  out  3  one-cycle pulse; column i was answered correctly.
- `score`  out  8  points, saturating at 255.
- `state`  out  2  IDLE=0, LAUNCH=1, RUN=2, OVER=3.

## Operation
- **Reset:** state=IDLE, score=0, div=DIV_INIT, active=000, all pulse outputs 0, all counters 0.
- **IDLE:**
  - Pulse outputs stay 0.
  - `start` → LAUNCH, with score=0, div=DIV_INIT, launch counter=0, step counter=0.
- **LAUNCH:**
  - Column i gets `spawn[i]` on the cycle the launch counter equals i*STAGGER, and active[i] is set on that same cycle.
  - Once column 2 has spawned, state → RUN on the next cycle.
  - Steps, arbitration and game-over apply to active columns only.
- **Step divider:**
  - Step counter counts 0..div-1.
  - On div-1, `step` = active mask and the counter returns to 0.
  - A change to div takes effect from the next period; the current period completes with the old count.
- **Arbitration:**
  - A column is eligible when it is active, not in holdoff, `match[i]=1` and `bottom[i]=0`.
  - Winner is the eligible column with the largest ypos; on a tie, the lowest index wins.
  - The winner gets `clear[i]` at cycle t, then `spawn[i]` at t+1.
  - The winner is ineligible from t+1 through t+HOLDOFF.
  - At most one `clear` bit is set per cycle.
  - `step` may coincide with `clear` or `spawn`; Column gives spawn priority.
- **Score:**
  - +1 per clear; it holds at 255 (saturates).
  - When the new score is nonzero and its low 3 bits are 000, div = max(div-DIV_STEP, DIV_MIN).
  - No speed change once score has saturated.
- **Game over:**
  - Any active column with `bottom[i]=1` in LAUNCH or RUN → OVER on the next cycle.
  - If that same cycle also has a matching column with `bottom=1`, it is not credited; game over wins.
  - Other columns may still clear that cycle.
- **OVER:**
  - Pulse outputs stay 0 and score is held.
  - `start` → LAUNCH, behaving exactly as from IDLE.
- `start` is ignored in LAUNCH and RUN.
- `reset` in any state returns everything to reset values on the next edge.

## Timing
- All outputs are registered.
- `clear` appears the cycle after `match` is sampled eligible; `spawn` follows one cycle later.
- `score` updates in the same cycle `clear` is high.
- `state` changes one cycle after the triggering input.
- First `step` falls DIV_INIT cycles after LAUNCH entry.
- `spawn[0]` appears on the first LAUNCH cycle.

## Test plan
Parameters for all scenarios: DIV_INIT=10, DIV_MIN=4, DIV_STEP=2, STAGGER=5, HOLDOFF=2.

1. **Reset and launch.** Assert reset, then pulse start → state 0→1. spawn=001, 010, 100 at LAUNCH cycles 0, 5, 10. state=2 at cycle 11. step pulses every 10 cycles, carrying the active mask.
2. **Arbitration.** match=111 with ypos1=3, ypos2=9, ypos3=9 → clear=010 only, then spawn=010, and score=1. Holding match=111 → the next clear is 100.
3. **Speed-up.** Drive 8 clears → score=8 and the step period becomes 8. At 24 points the period reaches 4, and at 32 it stays 4.
4. **Saturation.** Drive 300 clears → score stays 255.
5. **Simultaneous bottom and match.** bottom=001 with match=001 → no clear, score unchanged, state=3 next cycle, all pulses 0 after that. A later start → LAUNCH with score=0.
6. **Reset mid-run.** Assert reset during RUN with score=17 → next cycle state=0, score=0, all outputs 0.
